// File: rtl/mux_n_pipe_pkg.sv
// Shared definitions for the N:1 registered selector and its skid buffer.
package mux_n_pipe_pkg;

  // Largest number of selectable operands the selector is meant for
  localparam int MUX_N_MAX = 16;

  // Occupancy of the two-entry output buffer
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_e;

  // Select width for n inputs; a 2:1 selector still needs one bit
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_pipe_if.sv
// Operand/select handshake bundle between an operand source and the selector.
interface mux_n_pipe_if import mux_n_pipe_pkg::*; #(
  parameter int WIDTH = 5,
  parameter int N     = 4,
  parameter int SEL_W = sel_width(N)
);
  logic [N*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]   in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_err;
  logic               out_valid;
  logic               out_ready;

  // Upstream/downstream side that drives operands and accepts results
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );

  // Selector side
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid
  );
endinterface

// File: rtl/mux_n_pipe_skid_buf2.sv
// Two-entry skid buffer: a main (output) register plus one skid register so the
// upstream ready never depends combinationally on the downstream ready.
module skid_buf2 import mux_n_pipe_pkg::*; #(
  parameter int DW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  occ_e          state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          accept;
  logic          consume;

  // Outputs are decodes of flops only
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  // Occupancy transitions; the oldest entry always sits in main
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_d = in_data;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (consume) begin
            main_d  = '0;
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // State and data registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// Parametrised N:1 operand selector with registered output, out-of-range flag
// and valid/ready back-pressure through a two-entry skid buffer.
module mux_n_pipe import mux_n_pipe_pkg::*; #(
  parameter int WIDTH = 5,
  parameter int N     = 4,
  parameter int SEL_W = sel_width(N)
) (
  input logic        clk,
  input logic        reset,
  input logic        flush,
  mux_n_pipe_if.slave bus
);

  if (N < 2 || N > MUX_N_MAX) begin : g_bad_n
    $error("mux_n_pipe: N out of range");
  end
  if (SEL_W != sel_width(N)) begin : g_bad_sel_w
    $error("mux_n_pipe: SEL_W does not match clog2(N)");
  end

  logic [SEL_W-1:0] sel_idx;
  logic             sel_err;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH:0]   buf_out;

  // Resolve the select at acceptance time; out-of-range picks the last input
  always_comb begin
    sel_idx = bus.in_sel;
    sel_err = 1'b0;
    if (int'(bus.in_sel) >= N) begin
      sel_idx = SEL_W'(N - 1);
      sel_err = 1'b1;
    end
    sel_data = bus.in_data[int'(sel_idx)*WIDTH +: WIDTH];
  end

  skid_buf2 #(
    .DW(WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_data  ({sel_err, sel_data}),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .out_data (buf_out),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready)
  );

  assign bus.out_data = buf_out[WIDTH-1:0];
  assign bus.out_err  = buf_out[WIDTH];

endmodule
